// File: rtl/game_mode_sequencer.sv
// game_mode_sequencer: frame-synchronous title/play/pause/win/lose screen sequencer
module game_mode_sequencer #(
  parameter int MAX_LEVEL        = 9,
  parameter int BLINK_FRAMES     = 30,
  parameter int WIN_HOLD_FRAMES  = 120,
  parameter int LOSE_HOLD_FRAMES = 180
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       startKey,
  input  logic       pauseKey,
  input  logic       playerDead,
  input  logic       aliensCleared,
  output logic       isGameMode,
  output logic       splashShow,
  output logic [1:0] splashSel,
  output logic       splashBlink,
  output logic       gameRunning,
  output logic [3:0] level,
  output logic       newGame,
  output logic       newLevel
);
  localparam int HOLD_MAX = (WIN_HOLD_FRAMES > LOSE_HOLD_FRAMES) ? WIN_HOLD_FRAMES : LOSE_HOLD_FRAMES;
  localparam int HW = $clog2(HOLD_MAX + 1);
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  typedef enum logic [2:0] {TITLE, PLAY, PAUSE, WIN, LOSE} state_t;
  state_t state, state_nxt;
  logic start_prev, pause_prev;
  logic pend_start, pend_pause, pend_dead, pend_clr;
  logic [3:0] level_nxt;
  logic [HW-1:0] hold_cnt, hold_nxt, hold_lim;
  logic hold_done;
  logic [BW-1:0] blink_cnt, blink_cnt_nxt;
  logic blink_nxt, blink_wrap, stay_title;
  logic new_game_nxt, new_level_nxt;
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      state <= TITLE;
      level <= '0;
      hold_cnt <= '0;
      blink_cnt <= '0;
      splashBlink <= 1'b0;
      newGame <= 1'b0;
      newLevel <= 1'b0;
      start_prev <= 1'b0;
      pause_prev <= 1'b0;
      pend_start <= 1'b0;
      pend_pause <= 1'b0;
      pend_dead <= 1'b0;
      pend_clr <= 1'b0;
    end else begin
      state <= state_nxt;
      level <= level_nxt;
      hold_cnt <= hold_nxt;
      blink_cnt <= blink_cnt_nxt;
      splashBlink <= blink_nxt;
      newGame <= new_game_nxt;
      newLevel <= new_level_nxt;
      start_prev <= startKey;
      pause_prev <= pauseKey;
      pend_start <= (startKey & ~start_prev) | (pend_start & ~startOfFrame);
      pend_pause <= (pauseKey & ~pause_prev) | (pend_pause & ~startOfFrame);
      pend_dead <= playerDead | (pend_dead & ~startOfFrame);
      pend_clr <= aliensCleared | (pend_clr & ~startOfFrame);
    end
  always_comb begin
    state_nxt = state;
    level_nxt = level;
    new_game_nxt = 1'b0;
    new_level_nxt = 1'b0;
    hold_lim = (state == WIN) ? HW'(WIN_HOLD_FRAMES) : HW'(LOSE_HOLD_FRAMES);
    hold_done = hold_cnt == hold_lim;
    hold_nxt = hold_cnt;
    if (startOfFrame)
      case (state)
        TITLE: if (pend_start) begin
          state_nxt = PLAY;
          level_nxt = 4'd1;
          new_game_nxt = 1'b1;
        end
        PLAY: if (pend_dead) state_nxt = LOSE;
          else if (pend_clr) begin
            if (level < 4'(MAX_LEVEL)) begin
              level_nxt = level + 4'd1;
              new_level_nxt = 1'b1;
            end else state_nxt = WIN;
          end else if (pend_pause) state_nxt = PAUSE;
        PAUSE: if (pend_pause | pend_start) state_nxt = PLAY;
        WIN, LOSE: if (pend_start && hold_done) begin
          state_nxt = TITLE;
          level_nxt = '0;
        end else hold_nxt = hold_done ? hold_cnt : hold_cnt + 1'b1;
        default: state_nxt = TITLE;
      endcase
    if (state_nxt != state) hold_nxt = '0;
    stay_title = (state == TITLE) && (state_nxt == TITLE);
    blink_wrap = blink_cnt == BW'(BLINK_FRAMES - 1);
    blink_cnt_nxt = !stay_title ? '0 : !startOfFrame ? blink_cnt : blink_wrap ? '0 : blink_cnt + 1'b1;
    blink_nxt = stay_title && (splashBlink ^ (startOfFrame && blink_wrap));
  end
  always_comb begin
    splashShow = state != PLAY;
    splashSel = (state == PAUSE) ? 2'd1 : (state == WIN) ? 2'd2 : (state == LOSE) ? 2'd3 : 2'd0;
    isGameMode = (state == PLAY) || (state == PAUSE);
    gameRunning = state == PLAY;
  end
endmodule

// File: tb/tb_game_mode_sequencer.sv
// tb_game_mode_sequencer: randomized-timing directed bench against a frame-level reference model
module tb_game_mode_sequencer;
  localparam int MAXL = 9, BLINK = 30, WHOLD = 120, LHOLD = 180;
  localparam int M_TITLE = 0, M_PLAY = 1, M_PAUSE = 2, M_WIN = 3, M_LOSE = 4;
  logic clk = 0, resetN = 0, startOfFrame = 0, startKey = 0, pauseKey = 0, playerDead = 0, aliensCleared = 0;
  logic isGameMode, splashShow, splashBlink, gameRunning, newGame, newLevel;
  logic [1:0] splashSel;
  logic [3:0] level;
  int n_cmp = 0, n_bad = 0;
  int mode, lvl, mframes, ng_count;
  bit p_start, p_pause, p_dead, p_clr, prev_sk, prev_pk, e_ng, e_nl, hold_keys;
  always #5 clk = ~clk;
  game_mode_sequencer #(.MAX_LEVEL(MAXL), .BLINK_FRAMES(BLINK), .WIN_HOLD_FRAMES(WHOLD), .LOSE_HOLD_FRAMES(LHOLD)) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .startKey(startKey), .pauseKey(pauseKey),
    .playerDead(playerDead), .aliensCleared(aliensCleared), .isGameMode(isGameMode), .splashShow(splashShow),
    .splashSel(splashSel), .splashBlink(splashBlink), .gameRunning(gameRunning), .level(level),
    .newGame(newGame), .newLevel(newLevel)
  );
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    mode = M_TITLE; lvl = 0; mframes = 0;
    {p_start, p_pause, p_dead, p_clr, prev_sk, prev_pk, e_ng, e_nl} = '0;
  endtask
  task automatic check_outputs();
    chk("splashShow", 8'(splashShow), 8'(mode != M_PLAY));
    if (mode != M_PLAY) chk("splashSel", 8'(splashSel), 8'(mode == M_PAUSE ? 1 : mode == M_WIN ? 2 : mode == M_LOSE ? 3 : 0));
    chk("isGameMode", 8'(isGameMode), 8'(mode == M_PLAY || mode == M_PAUSE));
    chk("gameRunning", 8'(gameRunning), 8'(mode == M_PLAY));
    chk("level", 8'(level), 8'(lvl));
    chk("splashBlink", 8'(splashBlink), 8'(mode == M_TITLE ? (mframes / BLINK) % 2 : 0));
    chk("newGame", 8'(newGame), 8'(e_ng));
    chk("newLevel", 8'(newLevel), 8'(e_nl));
  endtask
  // Model of one clock edge: events accumulate between frames and are judged once per frame.
  task automatic model_edge();
    bit rs, rp;
    int nm;
    rs = startKey && !prev_sk;
    rp = pauseKey && !prev_pk;
    prev_sk = startKey; prev_pk = pauseKey;
    e_ng = 0; e_nl = 0;
    if (startOfFrame) begin
      nm = mode;
      if (mode == M_TITLE && p_start) begin nm = M_PLAY; lvl = 1; e_ng = 1; end
      else if (mode == M_PLAY) begin
        if (p_dead) nm = M_LOSE;
        else if (p_clr) begin
          if (lvl < MAXL) begin lvl++; e_nl = 1; end else nm = M_WIN;
        end else if (p_pause) nm = M_PAUSE;
      end else if (mode == M_PAUSE && (p_pause || p_start)) nm = M_PLAY;
      else if ((mode == M_WIN || mode == M_LOSE) && p_start && mframes >= (mode == M_WIN ? WHOLD : LHOLD)) begin
        nm = M_TITLE; lvl = 0;
      end
      mframes = (nm == mode) ? mframes + 1 : 0;
      mode = nm;
      p_start = rs; p_pause = rp; p_dead = playerDead; p_clr = aliensCleared;
    end else begin
      p_start |= rs; p_pause |= rp; p_dead |= playerDead; p_clr |= aliensCleared;
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    model_edge();
    check_outputs();
    ng_count += int'(newGame);
  endtask
  // ev = {start press, pause press, playerDead, aliensCleared}, all at cycle 'at' of the frame
  task automatic frame(input int len, input int at, input logic [3:0] ev);
    for (int c = 0; c < len; c++) begin
      startOfFrame = (c == 0);
      playerDead = (c == at) && ev[1];
      aliensCleared = (c == at) && ev[0];
      if (c == at && ev[3]) startKey = 1;
      if (c == at && ev[2]) pauseKey = 1;
      if (c == len - 1 && !hold_keys) begin startKey = 0; pauseKey = 0; end
      tick();
    end
  endtask
  task automatic rframe(input logic [3:0] ev);
    int len;
    len = $urandom_range(6, 12);
    frame(len, $urandom_range(1, len - 2), ev);
  endtask
  task automatic do_reset();
    {startOfFrame, startKey, pauseKey, playerDead, aliensCleared} = '0;
    #3 resetN = 0;
    #1 model_reset();
    check_outputs();
    chk("resetTitleSel", 8'(splashSel), 8'd0);
    @(posedge clk);
    #1 resetN = 1;
  endtask
  initial begin
    model_reset();
    hold_keys = 0;
    ng_count = 0;
    #2 check_outputs();
    repeat (2) @(posedge clk);
    #1 resetN = 1;
    repeat (3) rframe(4'b0000);
    chk("idleLevel", 8'(level), 8'd0);
    hold_keys = 1;
    rframe(4'b1000);
    repeat (4) rframe(4'b0000);
    hold_keys = 0;
    rframe(4'b0000);
    chk("newGameOnce", 8'(ng_count), 8'd1);
    chk("playLevel1", 8'(level), 8'd1);
    repeat (9) rframe(4'b0001);
    rframe(4'b0000);
    chk("winSel", 8'(splashSel), 8'd2);
    chk("winLevel", 8'(level), 8'(MAXL));
    rframe(4'b1000);
    rframe(4'b0000);
    chk("winEarlyStart", 8'(splashSel), 8'd2);
    do_reset();
    rframe(4'b1000);
    rframe(4'b0000);
    rframe(4'b0110);
    rframe(4'b0000);
    chk("deadWinsSel", 8'(splashSel), 8'd3);
    repeat (48) rframe(4'b0000);
    rframe(4'b1000);
    rframe(4'b0000);
    chk("loseEarlyStart", 8'(splashSel), 8'd3);
    repeat (140) rframe(4'b0000);
    rframe(4'b1000);
    rframe(4'b0000);
    chk("loseExitSel", 8'(splashShow), 8'd1);
    chk("loseExitLevel", 8'(level), 8'd0);
    repeat (65) rframe(4'b0000);
    rframe(4'b1000);
    rframe(4'b0000);
    rframe(4'b0100);
    rframe(4'b0000);
    chk("pauseRunning", 8'(gameRunning), 8'd0);
    chk("pauseGameMode", 8'(isGameMode), 8'd1);
    chk("pauseSel", 8'(splashSel), 8'd1);
    rframe(4'b0001);
    rframe(4'b0000);
    rframe(4'b0100);
    rframe(4'b0000);
    chk("resumeLevel", 8'(level), 8'd1);
    chk("resumeRunning", 8'(gameRunning), 8'd1);
    frame(8, 0, 4'b0001);
    chk("sofClrHeld", 8'(level), 8'd1);
    rframe(4'b0000);
    chk("sofClrApplied", 8'(level), 8'd2);
    repeat (80) rframe({4{1'b0}} | {1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) == 0),
                                     1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 2) == 0)});
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
